// File: rtl/atpg_response_checker.sv
// atpg_response_checker: applies test vectors to a circuit under test and compares its settled outputs with expected responses
module atpg_response_checker #(
   parameter int NIN    = 5,
   parameter int NOUT   = 2,
   parameter int SETTLE = 2,
   parameter int IDXW   = 8
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            clear,
   input  logic            vec_valid,
   output logic            vec_ready,
   input  logic [NIN-1:0]  vec_in,
   input  logic [NOUT-1:0] exp_in,
   input  logic            vec_last,
   output logic [NIN-1:0]  dut_in,
   input  logic [NOUT-1:0] dut_out,
   output logic            res_valid,
   output logic            res_mismatch,
   output logic [NOUT-1:0] res_diff,
   output logic [IDXW-1:0] res_idx,
   output logic [IDXW-1:0] fail_count,
   output logic            first_fail_valid,
   output logic [IDXW-1:0] first_fail_idx,
   output logic            done,
   output logic            pass
);
   typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_DONE} state_t;
   state_t          state_q;
   logic [7:0]      cnt_q;
   logic [IDXW-1:0] idx_q;
   logic [NOUT-1:0] exp_q;
   logic            last_q;
   logic [NOUT-1:0] diff_d;
   logic            mis_d;
   assign diff_d = dut_out ^ exp_q;
   assign mis_d  = |diff_d;
   // Handshake, settle countdown and compare; every output is registered here
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q          <= S_IDLE;
         cnt_q            <= '0;
         idx_q            <= '0;
         exp_q            <= '0;
         last_q           <= 1'b0;
         vec_ready        <= 1'b1;
         dut_in           <= '0;
         res_valid        <= 1'b0;
         res_mismatch     <= 1'b0;
         res_diff         <= '0;
         res_idx          <= '0;
         fail_count       <= '0;
         first_fail_valid <= 1'b0;
         first_fail_idx   <= '0;
         done             <= 1'b0;
         pass             <= 1'b0;
      end else if (clear) begin
         state_q          <= S_IDLE;
         cnt_q            <= '0;
         idx_q            <= '0;
         vec_ready        <= 1'b1;
         res_valid        <= 1'b0;
         res_mismatch     <= 1'b0;
         res_diff         <= '0;
         res_idx          <= '0;
         fail_count       <= '0;
         first_fail_valid <= 1'b0;
         first_fail_idx   <= '0;
         done             <= 1'b0;
         pass             <= 1'b0;
      end else begin
         res_valid <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (vec_valid) begin
                  dut_in    <= vec_in;
                  exp_q     <= exp_in;
                  last_q    <= vec_last;
                  idx_q     <= idx_q + 1'b1;
                  cnt_q     <= 8'(SETTLE - 1);
                  vec_ready <= 1'b0;
                  state_q   <= S_SETTLE;
               end
            end
            S_SETTLE: begin
               if (cnt_q != '0) begin
                  cnt_q <= cnt_q - 1'b1;
               end else begin
                  res_valid    <= 1'b1;
                  res_diff     <= diff_d;
                  res_mismatch <= mis_d;
                  res_idx      <= idx_q;
                  if (mis_d && fail_count != '1) fail_count <= fail_count + 1'b1;
                  if (mis_d && !first_fail_valid) begin
                     first_fail_valid <= 1'b1;
                     first_fail_idx   <= idx_q;
                  end
                  state_q   <= last_q ? S_DONE : S_IDLE;
                  vec_ready <= !last_q;
                  done      <= last_q;
                  pass      <= last_q && !mis_d && fail_count == '0;
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_atpg_response_checker.sv
// tb_atpg_response_checker: table vectors, corner sequences and randomized runs against a c17 reference model
module tb_atpg_response_checker;
   localparam int ST = 2;
   logic clk = 1'b0, rst = 1'b1, clear = 1'b0, vec_valid = 1'b0, vec_last = 1'b0;
   logic [4:0] vec_in = '0, dut_in;
   logic [1:0] exp_in = '0, dut_out, res_diff;
   logic vec_ready, res_valid, res_mismatch, first_fail_valid, done, pass;
   logic [7:0] res_idx, fail_count, first_fail_idx;
   bit fault = 1'b0;
   logic s_clear = 1'b0, s_vec_valid = 1'b0, s_vec_last = 1'b0;
   logic [4:0] s_vec_in = '0, s_dut_in;
   logic [1:0] s_exp_in = '0, s_dut_out, s_res_diff;
   logic s_vec_ready, s_res_valid, s_res_mismatch, s_ffv, s_done, s_pass;
   logic [1:0] s_res_idx, s_fail_count, s_ffi;
   int n_chk = 0, n_fail = 0;

   always #5 clk = ~clk;

   // Gate-level c17; f forces internal net N10 stuck-at-1
   function automatic logic [1:0] c17(input logic [4:0] v, input bit f);
      logic n1, n2, n3, n6, n7, n10, n11, n16, n19;
      {n1, n2, n3, n6, n7} = v;
      n10 = f ? 1'b1 : ~(n1 & n3);
      n11 = ~(n3 & n6);
      n16 = ~(n2 & n11);
      n19 = ~(n11 & n7);
      return {~(n10 & n16), ~(n16 & n19)};
   endfunction

   assign dut_out   = c17(dut_in, fault);
   assign s_dut_out = 2'b11;

   atpg_response_checker #(.NIN(5), .NOUT(2), .SETTLE(ST), .IDXW(8)) u_dut (
      .clk(clk), .rst(rst), .clear(clear), .vec_valid(vec_valid), .vec_ready(vec_ready),
      .vec_in(vec_in), .exp_in(exp_in), .vec_last(vec_last), .dut_in(dut_in), .dut_out(dut_out),
      .res_valid(res_valid), .res_mismatch(res_mismatch), .res_diff(res_diff), .res_idx(res_idx),
      .fail_count(fail_count), .first_fail_valid(first_fail_valid), .first_fail_idx(first_fail_idx),
      .done(done), .pass(pass));

   atpg_response_checker #(.NIN(5), .NOUT(2), .SETTLE(ST), .IDXW(2)) u_sat (
      .clk(clk), .rst(rst), .clear(s_clear), .vec_valid(s_vec_valid), .vec_ready(s_vec_ready),
      .vec_in(s_vec_in), .exp_in(s_exp_in), .vec_last(s_vec_last), .dut_in(s_dut_in), .dut_out(s_dut_out),
      .res_valid(s_res_valid), .res_mismatch(s_res_mismatch), .res_diff(s_res_diff), .res_idx(s_res_idx),
      .fail_count(s_fail_count), .first_fail_valid(s_ffv), .first_fail_idx(s_ffi),
      .done(s_done), .pass(s_pass));

   task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
      n_chk++;
      if (a !== e) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, a, e);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_clear();
      clear = 1'b1;
      tick();
      clear = 1'b0;
   endtask

   task automatic send(input logic [4:0] v, input logic [1:0] e, input bit l);
      int n;
      n = 0;
      while (!vec_ready && n < 50) begin tick(); n++; end
      chk("send_ready", vec_ready, 1);
      vec_valid = 1'b1; vec_in = v; exp_in = e; vec_last = l;
      tick();
      vec_valid = 1'b0; vec_last = 1'b0;
      chk("send_dut_in", dut_in, v);
      n = 0;
      do begin tick(); n++; end while (!res_valid && n < 50);
      chk("send_latency", n, ST);
   endtask

   typedef struct {
      logic [4:0] vec; logic [1:0] exp; bit fault, first, last;
      logic mism; logic [1:0] diff; int idx, fails, ffi; bit done, pass;
   } vec_t;
   vec_t tbl[5];

   typedef struct { logic [4:0] vec; logic [1:0] exp; bit last; int cyc; } txn_t;
   txn_t q[$];

   initial begin
      int acc, last_acc, nres, cyc, k, m_idx, m_fails, m_ffi;
      bit will, seen, m_ffv, in_done;
      logic [1:0] d;
      txn_t r;
      tbl[0] = '{5'b00010, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 1, 0, 0, 1'b1, 1'b1};
      tbl[1] = '{5'b00010, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 1, 0, 0, 1'b0, 1'b0};
      tbl[2] = '{5'b10111, 2'b10, 1'b1, 1'b0, 1'b1, 1'b1, 2'b10, 2, 1, 2, 1'b1, 1'b0};
      tbl[3] = '{5'b11111, 2'b11, 1'b0, 1'b1, 1'b0, 1'b1, 2'b01, 1, 1, 1, 1'b0, 1'b0};
      tbl[4] = '{5'b00000, 2'b11, 1'b0, 1'b0, 1'b1, 1'b1, 2'b11, 2, 2, 1, 1'b1, 1'b0};
      // reset state
      tick(); tick();
      chk("rst_ready", vec_ready, 1); chk("rst_dut_in", dut_in, 0);
      chk("rst_res_valid", res_valid, 0); chk("rst_res_idx", res_idx, 0);
      chk("rst_fail_count", fail_count, 0); chk("rst_ffv", first_fail_valid, 0);
      chk("rst_done", done, 0); chk("rst_pass", pass, 0);
      rst = 1'b0;
      tick();
      // table vectors
      foreach (tbl[i]) begin
         if (tbl[i].first) begin fault = tbl[i].fault; do_clear(); end
         send(tbl[i].vec, tbl[i].exp, tbl[i].last);
         chk("tbl_valid", res_valid, 1);
         chk("tbl_mismatch", res_mismatch, tbl[i].mism);
         chk("tbl_diff", res_diff, tbl[i].diff);
         chk("tbl_idx", res_idx, tbl[i].idx);
         chk("tbl_fails", fail_count, tbl[i].fails);
         chk("tbl_ffv", first_fail_valid, tbl[i].fails > 0);
         chk("tbl_ffi", first_fail_idx, tbl[i].ffi);
         chk("tbl_done", done, tbl[i].done);
         chk("tbl_pass", pass, tbl[i].pass);
         tick();
         chk("tbl_pulse", res_valid, 0);
      end
      // back-to-back throughput
      fault = 1'b0;
      do_clear();
      acc = 0; nres = 0; cyc = 0; last_acc = 0;
      vec_valid = 1'b1; vec_in = 5'($urandom); exp_in = c17(vec_in, 1'b0); vec_last = 1'b0;
      while (nres < 10 && cyc < 100) begin
         will = vec_valid && vec_ready;
         tick(); cyc++;
         if (will) begin
            acc++;
            if (acc > 1) chk("b2b_gap", cyc - last_acc, 3);
            last_acc = cyc;
            vec_in = 5'($urandom); exp_in = c17(vec_in, 1'b0);
            vec_last = (acc == 9);
            if (acc == 10) vec_valid = 1'b0;
         end
         if (res_valid) begin
            nres++;
            chk("b2b_idx", res_idx, nres);
            chk("b2b_mismatch", res_mismatch, 0);
            chk("b2b_done", done, nres == 10);
         end
      end
      chk("b2b_count", nres, 10);
      vec_last = 1'b0;
      // DONE ignores vec_valid
      vec_valid = 1'b1; seen = 1'b0;
      repeat (5) begin tick(); seen |= res_valid; end
      vec_valid = 1'b0;
      chk("done_hold", done, 1); chk("done_pass", pass, 1);
      chk("done_no_res", seen, 0); chk("done_ready", vec_ready, 0); chk("done_idx", res_idx, 10);
      // clear one cycle after acceptance
      do_clear();
      vec_valid = 1'b1; vec_in = 5'b00010; exp_in = 2'b11;
      tick();
      vec_valid = 1'b0;
      clear = 1'b1; tick(); clear = 1'b0;
      seen = 1'b0;
      repeat (5) begin tick(); seen |= res_valid; end
      chk("clr_no_res", seen, 0); chk("clr_ready", vec_ready, 1);
      chk("clr_fails", fail_count, 0); chk("clr_dut_in", dut_in, 5'b00010);
      send(5'b00010, 2'b00, 1'b1);
      chk("clr_idx_restart", res_idx, 1);
      // reset during SETTLE
      do_clear();
      vec_valid = 1'b1; vec_in = 5'b10111; exp_in = 2'b00;
      tick();
      vec_valid = 1'b0;
      #2 rst = 1'b1;
      #1;
      chk("mrst_ready", vec_ready, 1); chk("mrst_dut_in", dut_in, 0);
      chk("mrst_res_valid", res_valid, 0); chk("mrst_res_idx", res_idx, 0);
      chk("mrst_fails", fail_count, 0); chk("mrst_done", done, 0);
      tick();
      rst = 1'b0;
      seen = 1'b0;
      repeat (4) begin tick(); seen |= res_valid; end
      chk("mrst_no_res", seen, 0);
      // saturation and index wrap on the 2-bit instance
      s_clear = 1'b1; tick(); s_clear = 1'b0;
      for (int n = 1; n <= 5; n++) begin
         k = 0;
         while (!s_vec_ready && k < 20) begin tick(); k++; end
         s_vec_valid = 1'b1; s_vec_in = 5'($urandom); s_exp_in = 2'b00; s_vec_last = (n == 5);
         tick();
         s_vec_valid = 1'b0; s_vec_last = 1'b0;
         k = 0;
         do begin tick(); k++; end while (!s_res_valid && k < 20);
         chk("sat_valid", s_res_valid, 1);
         chk("sat_idx", s_res_idx, n % 4);
         chk("sat_fails", s_fail_count, n < 3 ? n : 3);
         chk("sat_ffi", s_ffi, 1);
         chk("sat_done", s_done, n == 5);
      end
      // randomized runs against a transaction-level model
      fault = 1'b0;
      do_clear();
      m_idx = 0; m_fails = 0; m_ffv = 1'b0; m_ffi = 0; in_done = 1'b0; cyc = 0;
      for (int c = 0; c < 800; c++) begin
         will = vec_valid && vec_ready && !clear;
         tick(); cyc++;
         clear = 1'b0;
         if (will) q.push_back('{vec_in, exp_in, vec_last, cyc});
         if (q.size() > 0 && q[0].cyc + ST == cyc) begin
            r = q.pop_front();
            m_idx = (m_idx + 1) % 256;
            d = c17(r.vec, fault) ^ r.exp;
            if (d != 0) begin
               if (m_fails < 255) m_fails++;
               if (!m_ffv) begin m_ffv = 1'b1; m_ffi = m_idx; end
            end
            chk("rnd_valid", res_valid, 1);
            chk("rnd_diff", res_diff, d);
            chk("rnd_mismatch", res_mismatch, d != 0);
            chk("rnd_idx", res_idx, m_idx);
            chk("rnd_fails", fail_count, m_fails);
            chk("rnd_ffv", first_fail_valid, m_ffv);
            chk("rnd_ffi", first_fail_idx, m_ffi);
            chk("rnd_done", done, r.last);
            chk("rnd_pass", pass, r.last && m_fails == 0);
            in_done = r.last;
         end else begin
            chk("rnd_idle", res_valid, 0);
         end
         if (in_done) begin
            clear = 1'b1; vec_valid = 1'b0; in_done = 1'b0;
            fault = 1'($urandom);
            m_idx = 0; m_fails = 0; m_ffv = 1'b0; m_ffi = 0;
         end else begin
            vec_valid = $urandom_range(0, 3) != 0;
            vec_in = 5'($urandom);
            exp_in = $urandom_range(0, 1) ? c17(vec_in, 1'b0) : 2'($urandom);
            vec_last = $urandom_range(0, 5) == 0;
         end
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/atpg_response_checker.md
# atpg_response_checker

Synthesizable response-side counterpart to the fault-injection stimulus flow. It accepts test vectors paired with fault-free expected responses over a valid/ready handshake and drives each vector onto the circuit-under-test inputs. After a programmable settle time it samples the circuit outputs, compares them against the expected response, and reports per-vector pass/fail plus a run summary. It sits between a vector source (ROM or host FIFO) and a combinational benchmark netlist such as c17.

## Interface
Parameters:
- NIN, 5, circuit-under-test input width; for c17, vec_in = {N1,N2,N3,N6,N7}, MSB = N1
- NOUT, 2, circuit-under-test output width; for c17, exp_in/dut_out = {N22,N23}
- SETTLE, 2, cycles between driving dut_in and sampling dut_out; legal range 1..255
- IDXW, 8, width of vector index and fail counter

Ports:
- clk  in  1  single clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- clear  in  1  synchronous run restart
- vec_valid  in  1  source has a vector
- vec_ready  out  1  checker can accept a vector
- vec_in  in  NIN  stimulus vector
- exp_in  in  NOUT  expected fault-free response
- vec_last  in  1  marks the final vector of the run
- dut_in  out  NIN  registered drive to circuit-under-test inputs
- dut_out  in  NOUT  circuit-under-test outputs
- res_valid  out  1  one-cycle pulse when a comparison result is available
- res_mismatch  out  1  result was a mismatch (qualified by res_valid)
- res_diff  out  NOUT  dut_out XOR expected (qualified by res_valid)
- res_idx  out  IDXW  1-based index of the compared vector
- fail_count  out  IDXW  mismatching vectors so far; saturating
- first_fail_valid  out  1  at least one mismatch has occurred
- first_fail_idx  out  IDXW  index of the first mismatching vector
- done  out  1  last vector has been compared
- pass  out  1  done and fail_count == 0

## Operation
- **States:**
  - IDLE: vec_ready=1.
  - SETTLE: vec_ready=0; counter cnt runs.
  - DONE: vec_ready=0, done=1.
- **IDLE → SETTLE** on vec_valid && vec_ready. The transfer does all of the following:
  - dut_in ← vec_in, exp_q ← exp_in, last_q ← vec_last.
  - idx ← idx+1 (wraps modulo 2^IDXW).
  - cnt ← SETTLE-1.
- **SETTLE, cnt != 0:** cnt decrements.
- **SETTLE, cnt == 0:** at the edge, compare dut_out against exp_q. Registered results:
  - res_valid=1, res_diff = dut_out ^ exp_q, res_mismatch = |res_diff, res_idx = idx.
  - On a mismatch: fail_count increments, saturating at 2^IDXW-1.
  - If first_fail_valid was 0, latch first_fail_idx=idx and set first_fail_valid=1.
  - Next state is DONE if last_q is set, otherwise IDLE.
- **DONE:** held until clear or rst. vec_valid is ignored.
- **dut_in hold:** dut_in keeps its value after the compare until the next accepted vector.
- **clear:** has priority over every other event. It returns the block to IDLE and zeros idx, fail_count, first_fail_*, res_*, done and cnt. dut_in is unchanged. Clear during SETTLE aborts the vector, and no res_valid is produced for it.
- **res_idx and res_diff** hold their values between res_valid pulses.

## Timing
- **Reset values:**
  - vec_ready=1, dut_in=0, res_valid=0, res_mismatch=0, res_diff=0, res_idx=0.
  - fail_count=0, first_fail_valid=0, first_fail_idx=0, done=0, pass=0.
  - State is IDLE.
- **Mid-run reset:** rst asserted mid-run forces the reset values immediately. No pending result is emitted.
- **Per-vector timing:**
  - Vector accepted at edge E0; dut_in is valid from E0.
  - dut_out is sampled at edge E0+SETTLE.
  - res_valid is high during cycle [E0+SETTLE, E0+SETTLE+1).
  - vec_ready returns to 1 at E0+SETTLE, unless the vector was the last one.
- **Throughput:** one vector per SETTLE+1 cycles when vec_valid is held high.
- **Done timing:** done and pass assert in the same cycle as the final res_valid.
- **Source stall:** vec_valid low in IDLE simply waits. No timeout.

## Test plan
- **Fault-free c17, vector 1:** vec_in=5'b00010, exp=2'b00, dut_out driven from a good c17, vec_last=1. Required response:
  - res_valid at E0+2 with res_mismatch=0, res_idx=1.
  - done=1, pass=1.
- **c17 with N10 stuck-at-1, vectors 1 and 5:**
  - Vector 1 (5'b00010, exp 2'b00) → no mismatch.
  - Vector 5 (5'b10111, exp 2'b10, vec_last=1) → res_mismatch=1, res_diff=2'b10, res_idx=2.
  - Final summary: fail_count=1, first_fail_idx=2, pass=0.
- **Back-to-back throughput:** 10 vectors with vec_valid held high and SETTLE=2. Required response:
  - Acceptances exactly every 3 cycles.
  - res_idx runs 1..10.
  - done asserts on the 10th result.
- **Mid-settle events:**
  - clear asserted one cycle after acceptance → no res_valid, idx=0, state IDLE.
  - rst asserted in SETTLE → all outputs at reset values within the same cycle.
- **Saturation/wrap (IDXW=2):** 5 mismatching vectors. Required response:
  - fail_count saturates at 3.
  - res_idx sequence is 1,2,3,0,1.
  - first_fail_idx stays 1.
